// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues one outstanding I-cache read, buffers {pc,instr} for decode.
// Latency imem_resp -> id_valid is 1 cycle (0 with FETCH_BYPASS_EN); decode stall gates new requests via FIFO space.
// Redirects flush the buffer; an in-flight stale response is drained and dropped (optional macro: FETCH_BYPASS_EN).
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0060,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [31:0]        fetch_pc, fetch_pc_nxt;
    logic [31:0]        req_addr, req_addr_nxt;
    logic [31:0]        redir_pc;
    logic [31:0]        seq_pc;

    logic [63:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_pop, count_post;
    logic               head_vld;
    logic               resp_ok;
    logic               push, pop;

    assign redir_pc = {redirect_pc[31:2], 2'b00};
    assign seq_pc   = req_addr + 32'd4;
    assign head_vld = (count != '0);
    assign resp_ok  = (state == REQ) && imem_resp && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    logic byp;
    // An empty buffer lets the returning word go straight to decode; it is only stored if decode stalls.
    assign byp      = !head_vld && resp_ok;
    assign id_valid = head_vld || byp;
    assign id_instr = byp ? imem_rdata : mem[rd_ptr][31:0];
    assign id_pc    = byp ? req_addr   : mem[rd_ptr][63:32];
    assign push     = resp_ok && !(byp && id_ready);
`else
    assign id_valid = head_vld;
    assign id_instr = mem[rd_ptr][31:0];
    assign id_pc    = mem[rd_ptr][63:32];
    assign push     = resp_ok;
`endif

    assign pop        = head_vld && id_ready && !redirect_valid;
    assign count_pop  = count - CNT_W'(pop);
    assign count_post = count + CNT_W'(push) - CNT_W'(pop);

    assign id_opcode    = id_instr[6:0];
    assign id_funct3    = id_instr[14:12];
    assign imem_read    = (state != IDLE);
    assign imem_address = req_addr;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    state_nxt    = REQ;
                    fetch_pc_nxt = redir_pc;
                    req_addr_nxt = redir_pc;
                end else if (count_pop < DEPTH_C) begin
                    state_nxt    = REQ;
                    req_addr_nxt = fetch_pc;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redir_pc;
                    if (imem_resp) begin
                        req_addr_nxt = redir_pc;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else if (imem_resp) begin
                    fetch_pc_nxt = seq_pc;
                    if (count_post < DEPTH_C) begin
                        req_addr_nxt = seq_pc;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                // The old request must complete on the bus before the new target is issued.
                if (redirect_valid) begin
                    fetch_pc_nxt = redir_pc;
                end
                if (imem_resp) begin
                    state_nxt    = REQ;
                    req_addr_nxt = redirect_valid ? redir_pc : fetch_pc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {req_addr, imem_rdata};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_post;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected {pc,instr} entries, a monitor checks decode handshakes.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_funct3(id_funct3)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[7:0], 1'b0, a[8:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] a, input bit keep);
        chk("req_read", {31'd0, imem_read}, 32'd1);
        chk("req_addr", imem_address, a);
        imem_resp  = 1'b1;
        imem_rdata = instr_of(a);
        if (keep) exp_q.push_back({a, instr_of(a)});
    endtask

    task automatic redirect(input logic [31:0] p);
        redirect_valid = 1'b1;
        redirect_pc    = p;
        exp_q.delete();
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && id_valid && id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry_pc", id_pc, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", id_pc, e[63:32]);
                    chk("id_instr", id_instr, e[31:0]);
                    chk("id_opcode", {25'd0, id_opcode}, {25'd0, e[6:0]});
                    chk("id_funct3", {29'd0, id_funct3}, {29'd0, e[14:12]});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read", {31'd0, imem_read}, 32'd0);
        chk("rst_addr", imem_address, 32'h60);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch with decode always ready
        tick(); resp(32'h60, 1);
        tick(); resp(32'h64, 1);
        tick(); resp(32'h68, 1);
        tick(); tick();

        // Decode stall: two pushes fill the buffer, then requests stop
        tick(); id_ready = 1'b0; resp(32'h6C, 1);
        tick(); resp(32'h70, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stall_read", {31'd0, imem_read}, 32'd0);
            chk("stall_valid", {31'd0, id_valid}, 32'd1);
            chk("stall_pc", id_pc, 32'h6C);
        end
        tick(); id_ready = 1'b1;
        tick(); resp(32'h74, 1);
        tick();

        // Redirect coinciding with a response
        tick(); redirect(32'h200); resp(32'h78, 0);
        tick(); chk("redir_empty", {31'd0, id_valid}, 32'd0); resp(32'h200, 1);

        // Redirect with request pending: drain old address
        tick(); redirect(32'h300);
        tick(); chk("drain_addr1", imem_address, 32'h204); chk("drain_valid", {31'd0, id_valid}, 32'd0);
        tick(); chk("drain_addr2", imem_address, 32'h204); chk("drain_read", {31'd0, imem_read}, 32'd1);
        tick(); resp(32'h204, 0);
        tick(); chk("drain_nopush", {31'd0, id_valid}, 32'd0); resp(32'h300, 1);
        tick(); redirect(32'h400);
        tick(); redirect(32'h500); chk("drain_addr3", imem_address, 32'h304);
        tick(); resp(32'h304, 0);
        tick(); resp(32'h500, 1);

        // Wraparound and redirect alignment
        tick(); redirect(32'hFFFF_FFFC);
        tick(); resp(32'h504, 0);
        tick(); resp(32'hFFFF_FFFC, 1);
        tick(); resp(32'h0, 1);
        tick();
        tick(); redirect(32'h103);
        tick(); resp(32'h4, 0);
        tick(); resp(32'h100, 1);
        tick();
        tick();

        // Asynchronous reset in the middle of a request
        tick();
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_read", {31'd0, imem_read}, 32'd0);
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); resp(32'h60, 1);
        tick(); tick();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
